// File: rtl/mem_wb_stage_reg.sv
// MEM->WB pipeline register with valid/ready handshake, flush, x0 write suppression
// and an optional second (skid) entry that keeps in_ready coming straight from a flop.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_EMPTY | no entry held, out_valid low
//   S_ONE   | main entry valid and driving the outputs, skid empty
//   S_FULL  | main and skid both valid, in_ready low (SKID_EN=1 only)
module mem_wb_stage_reg #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int SKID_EN = 1
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               FLUSH,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               MUX3_select,
    input  logic               regwrite_enable,
    input  logic [XLEN-1:0]    ALU_out,
    input  logic [XLEN-1:0]    read_data,
    input  logic [RADDR_W-1:0] rd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               MUX3_select_out,
    output logic               regwrite_enable_out,
    output logic [XLEN-1:0]    ALU_out_out,
    output logic [XLEN-1:0]    read_data_out,
    output logic [RADDR_W-1:0] rd_out,
    output logic [XLEN-1:0]    wb_data
);

    typedef struct packed {
        logic               mux_sel;
        logic               regwrite;
        logic [XLEN-1:0]    alu;
        logic [XLEN-1:0]    rdata;
        logic [RADDR_W-1:0] rd;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t r_state;
    entry_t r_main;
    entry_t r_skid;
    logic   r_in_ready;

    entry_t w_in_entry;
    logic   w_in_fire;
    logic   w_out_fire;
    logic   w_in_ready;
    logic   w_out_valid;

    assign w_in_entry = '{mux_sel:  MUX3_select,
                          regwrite: regwrite_enable,
                          alu:      ALU_out,
                          rdata:    read_data,
                          rd:       rd};

    assign w_out_valid = (r_state != S_EMPTY) & RESET_N;

    // Without a skid entry the stage can only take a new entry when the head leaves.
    assign w_in_ready = (SKID_EN != 0) ? (r_in_ready & RESET_N)
                                       : ((!w_out_valid | out_ready) & RESET_N);

    assign w_in_fire  = in_valid & w_in_ready;
    assign w_out_fire = w_out_valid & out_ready;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state    <= S_EMPTY;
            r_main     <= '0;
            r_skid     <= '0;
            r_in_ready <= 1'b1;
        end else if (FLUSH) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_fire) begin
                        r_main  <= w_in_entry;
                        r_state <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main <= w_in_entry;
                    end else if (w_in_fire) begin
                        if (SKID_EN != 0) begin
                            r_skid     <= w_in_entry;
                            r_state    <= S_FULL;
                            r_in_ready <= 1'b0;
                        end
                    end else if (w_out_fire) begin
                        r_state <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_out_fire) begin
                        r_main     <= r_skid;
                        r_state    <= S_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_EMPTY;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    // Fields are forced to zero while reset is held so nothing stale leaks out.
    assign in_ready            = w_in_ready;
    assign out_valid           = w_out_valid;
    assign MUX3_select_out     = r_main.mux_sel & RESET_N;
    assign ALU_out_out         = r_main.alu & {XLEN{RESET_N}};
    assign read_data_out       = r_main.rdata & {XLEN{RESET_N}};
    assign rd_out              = r_main.rd & {RADDR_W{RESET_N}};
    assign regwrite_enable_out = r_main.regwrite & w_out_valid & (r_main.rd != '0);
    assign wb_data             = MUX3_select_out ? read_data_out : ALU_out_out;

endmodule

// File: doc/mem_wb_stage_reg.md
# mem_wb_stage_reg

Parametrised MEM→WB pipeline register for the RV32IM core, replacing the fixed single-flop stage register with a valid/ready handshake stage. It carries the write-back mux select, register-write enable, ALU result, load data and destination register from the memory stage to the write-back stage. It adds stall backpressure, flush, and an optional two-entry skid buffer, and suppresses writes to x0. It sits between the data-memory stage and the register-file write port.

## Interface
- XLEN, 32, width of ALU result and load data
- RADDR_W, 5, destination-register index width
- SKID_EN, 1, 1 = two-entry skid buffer (registered in_ready); 0 = single entry (combinational in_ready)

- CLK  in  1  clock; all state updates on rising edge
- RESET_N  in  1  reset; one clock, reset is synchronous and active-low
- FLUSH  in  1  discard all held entries and any same-cycle input
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept this cycle
- MUX3_select  in  1  write-back source select (0 = ALU, 1 = memory)
- regwrite_enable  in  1  entry writes the register file
- ALU_out  in  XLEN  ALU result
- read_data  in  XLEN  load data
- rd  in  RADDR_W  destination register
- out_valid  out  1  head entry valid
- out_ready  in  1  write-back consumes head entry
- MUX3_select_out  out  1  head-entry field
- regwrite_enable_out  out  1  head regwrite, gated (see Operation)
- ALU_out_out  out  XLEN  head-entry field
- read_data_out  out  XLEN  head-entry field
- rd_out  out  RADDR_W  head-entry field
- wb_data  out  XLEN  MUX3_select_out ? read_data_out : ALU_out_out

## Operation
- Storage: main entry (drives outputs) plus, when SKID_EN=1, one skid entry. Each entry holds all five fields and a valid bit.
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- Occupancy states:
  - EMPTY: out_valid=0.
    - in_fire → ONE; main loaded.
  - ONE:
    - in_fire & out_fire → ONE; main replaced by the input.
    - in_fire & !out_fire → FULL; skid loaded, main held.
    - !in_fire & out_fire → EMPTY.
    - Neither → hold.
  - FULL (SKID_EN=1 only): in_ready=0.
    - out_fire → ONE; main ← skid.
    - Otherwise hold.
- in_ready:
  - SKID_EN=1: in_ready = !skid_valid & RESET_N, driven straight from a flop.
  - SKID_EN=0: in_ready = (!out_valid | out_ready) & RESET_N. FULL is unreachable.
- regwrite_enable_out = main.regwrite & out_valid & (rd_out != 0). This is never 1 for a bubble or for x0.
- Entries leave strictly in arrival order. No entry is duplicated or dropped except by FLUSH or reset.
- FLUSH:
  - Next edge: both valid bits ← 0, state → EMPTY.
  - Same-cycle in_fire is discarded.
  - Data fields may retain stale values, but every valid-gated output reads as a bubble.
- Priority: RESET_N low > FLUSH > normal handshake.

## Timing
- Reset value of every output while RESET_N=0 and on the first edge after release: out_valid=0, regwrite_enable_out=0, MUX3_select_out=0, ALU_out_out=0, read_data_out=0, rd_out=0, wb_data=0.
- in_ready is 0 during reset and 1 in the first cycle after release.
- Reset asserted mid-operation: all held entries are lost at the next edge. Any in_valid during reset is ignored.
- Latency: an entry accepted at edge N is on the outputs, with out_valid=1, after edge N.
- Throughput: one entry per cycle with out_ready held high, for both SKID_EN values.
- SKID_EN=1: when out_ready drops while in_valid is high, exactly one extra entry is absorbed. in_ready falls one cycle later and rises the cycle after the first out_fire in FULL.
- Held outputs are stable while out_valid=1 and out_ready=0.
- wb_data is combinational from the main entry, with no extra latency.

## Test plan
- Reset: drive RESET_N=0 for 2 cycles with in_valid=1 and ALU_out=0xDEADBEEF. Required: all outputs 0 and in_ready=0 throughout; out_valid=0 on the first cycle after release.
- Streaming: out_ready=1; send rd=1..8 with ALU_out=0x100+i, one per cycle. Required: out_valid from the cycle after the first send; rd_out 1..8 consecutively with no gaps.
- Backpressure (SKID_EN=1):
  - Send rd=3, 4, 5 back-to-back, with out_ready=0 from the cycle rd=3 appears.
  - Required: rd=4 is absorbed into skid, in_ready=0, rd=5 is held upstream.
  - Raise out_ready: rd 3, 4, 5 are delivered in order.
- Flush: hold two entries (FULL), then assert FLUSH together with in_valid (rd=7). Required next cycle: out_valid=0, regwrite_enable_out=0, in_ready=1; rd=7 is never output.
- x0 suppression and write-back mux:
  - Entry rd=0, regwrite_enable=1 → regwrite_enable_out=0.
  - Entry rd=9, MUX3_select=1, read_data=0xCAFE0001 → wb_data=0xCAFE0001.
- SKID_EN=0 rerun of the backpressure test: in_ready follows out_ready in the same cycle; no entry is lost or duplicated.
